// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: shared widths, alu_op codes, operand selects and mul/div FSM encodings
package exe_stage_pkg;
    localparam int ALU_OP_LENGTH    = 4;
    localparam int ALUopnd1_LENGTH  = 2;
    localparam int ALUopnd2_LENGTH  = 2;
    localparam int WDATA_SRC_LENGTH = 2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_MULT = 4'd12;
    localparam logic [3:0] ALU_DIV  = 4'd13;
    localparam logic [3:0] ALU_MFHI = 4'd14;
    localparam logic [3:0] ALU_MFLO = 4'd15;
    localparam logic [3:0] ALU_OP_DEFAULT = ALU_ADD;

    localparam logic [1:0] OP1_REG  = 2'b00;
    localparam logic [1:0] OP1_SA   = 2'b01;
    localparam logic [1:0] OP1_PC8  = 2'b10;
    localparam logic [1:0] OP2_REG  = 2'b00;
    localparam logic [1:0] OP2_EXT  = 2'b01;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction
endpackage

// File: rtl/exe_stage_mul_div_unit.sv
// mul_div_unit: 32-cycle signed shift-add multiplier and restoring divider owning HI/LO
module mul_div_unit
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);
    logic [1:0]  state;
    logic [4:0]  count;
    logic [63:0] p, p_nx, prod;
    logic [31:0] d, q_f, r_f;
    logic        qs, rs;
    logic [32:0] sum, r_sh, diff;
    // p holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        sum  = {1'b0, p[63:32]} + {1'b0, p[0] ? d : 32'd0};
        r_sh = {p[63:32], p[31]};
        diff = r_sh - {1'b0, d};
        p_nx = state == S_MUL ? {sum, p[31:1]} :
               diff[32] ? {r_sh[31:0], p[30:0], 1'b0} : {diff[31:0], p[30:0], 1'b1};
        prod = qs ? -p_nx : p_nx;
        q_f  = qs ? -p_nx[31:0] : p_nx[31:0];
        r_f  = rs ? -p_nx[63:32] : p_nx[63:32];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            p     <= '0;
            d     <= '0;
            qs    <= 1'b0;
            rs    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (state == S_IDLE) begin
            if (start && is_div && b == '0) begin
                hi <= a;
                lo <= '1;
            end else if (start) begin
                state <= is_div ? S_DIV : S_MUL;
                count <= '0;
                p     <= {32'd0, is_div ? abs32(a) : abs32(b)};
                d     <= is_div ? abs32(b) : abs32(a);
                qs    <= a[31] ^ b[31];
                rs    <= a[31];
            end
        end else begin
            p     <= p_nx;
            count <= count + 5'd1;
            if (count == 5'd31) begin
                state <= S_IDLE;
                hi    <= state == S_MUL ? prod[63:32] : r_f;
                lo    <= state == S_MUL ? prod[31:0] : q_f;
            end
        end
    end
    assign busy = state != S_IDLE;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: operand select, single-cycle ALU, mul/div stall control and EXE/MEM register
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WDATA_SRC_LENGTH-1:0] WriteDataSrc_in,
    input  logic                        DataMemWE_in,
    input  logic                        RegWE_in,
    input  logic [4:0]                  reg_write_addr_in,
    input  logic [ALU_OP_LENGTH-1:0]    alu_op_in,
    input  logic [ALUopnd1_LENGTH-1:0]  ALUopnd1src_in,
    input  logic [ALUopnd2_LENGTH-1:0]  ALUopnd2src_in,
    input  logic [31:0]                 reg1data_in,
    input  logic [31:0]                 reg2data_in,
    input  logic [31:0]                 extended_data_in,
    input  logic [31:0]                 PCplus8_in,
    input  logic [4:0]                  sa_in,
    output logic [31:0]                 alu_result_out,
    output logic [31:0]                 store_data_out,
    output logic [WDATA_SRC_LENGTH-1:0] WriteDataSrc_out,
    output logic                        DataMemWE_out,
    output logic                        RegWE_out,
    output logic [4:0]                  reg_write_addr_out,
    output logic                        md_stall
);
    logic [31:0] opnd1, opnd2, alu, hi, lo;
    logic        busy, is_md;
    always_comb begin
        opnd1 = ALUopnd1src_in == OP1_REG ? reg1data_in :
                ALUopnd1src_in == OP1_SA  ? {27'd0, sa_in} :
                ALUopnd1src_in == OP1_PC8 ? PCplus8_in : 32'd0;
        opnd2 = ALUopnd2src_in == OP2_REG ? reg2data_in :
                ALUopnd2src_in == OP2_EXT ? extended_data_in : 32'd0;
        case (alu_op_in)
            ALU_SUB:  alu = opnd1 - opnd2;
            ALU_AND:  alu = opnd1 & opnd2;
            ALU_OR:   alu = opnd1 | opnd2;
            ALU_XOR:  alu = opnd1 ^ opnd2;
            ALU_NOR:  alu = ~(opnd1 | opnd2);
            ALU_SLL:  alu = opnd2 << opnd1[4:0];
            ALU_SRL:  alu = opnd2 >> opnd1[4:0];
            ALU_SRA:  alu = $signed(opnd2) >>> opnd1[4:0];
            ALU_SLT:  alu = {31'd0, $signed(opnd1) < $signed(opnd2)};
            ALU_SLTU: alu = {31'd0, opnd1 < opnd2};
            ALU_LUI:  alu = opnd2 << 16;
            ALU_MULT: alu = 32'd0;
            ALU_DIV:  alu = 32'd0;
            ALU_MFHI: alu = hi;
            ALU_MFLO: alu = lo;
            default:  alu = opnd1 + opnd2;
        endcase
    end
    assign is_md    = alu_op_in == ALU_MULT || alu_op_in == ALU_DIV;
    assign md_stall = !rst && busy && alu_op_in[3:2] == 2'b11;

    mul_div_unit u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (is_md && !busy),
        .is_div (alu_op_in == ALU_DIV),
        .a      (opnd1),
        .b      (opnd2),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy)
    );

    always_ff @(posedge clk) begin
        if (rst || md_stall) begin
            alu_result_out     <= '0;
            store_data_out     <= '0;
            WriteDataSrc_out   <= '0;
            DataMemWE_out      <= 1'b0;
            RegWE_out          <= 1'b0;
            reg_write_addr_out <= '0;
        end else begin
            alu_result_out     <= alu;
            store_data_out     <= reg2data_in;
            WriteDataSrc_out   <= WriteDataSrc_in;
            DataMemWE_out      <= DataMemWE_in && !is_md;
            RegWE_out          <= RegWE_in && !is_md;
            reg_write_addr_out <= reg_write_addr_in;
        end
    end
endmodule
